ulpi_reg_arbiter: RTL

- Shares the single ULPI register-access port of the UTMI-to-ULPI bridge (reg_req/reg_rd/reg_addr/reg_wdata → reg_req_done/reg_rdata) among NUM_REQ requesters, e.g. PHY init sequencer, debug bridge, OTG control.
- Round-robin arbitration; one transaction in flight at a time.
- Sits between the requesters and the bridge's io_reg_* port.

---
 rtl/ulpi_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/ulpi_reg_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ulpi_pkg.sv
// ULPI shared definitions.
//   - arb_state_e : register-port arbiter states (ARB_IDLE/ARB_BUSY/ARB_RELEASE)
//   - reg_txn_t   : one latched register transaction (rd, addr, wdata)
//   - ULPI immediate register addresses, also used by the bridge bench.
package ulpi_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
  } reg_txn_t;

  // ULPI immediate register map (write address; set/clear aliases at +1/+2)
  localparam logic [7:0] VENDOR_ID_LO  = 8'h00;
  localparam logic [7:0] VENDOR_ID_HI  = 8'h01;
  localparam logic [7:0] PRODUCT_ID_LO = 8'h02;
  localparam logic [7:0] PRODUCT_ID_HI = 8'h03;
  localparam logic [7:0] FUNC_CTRL     = 8'h04;
  localparam logic [7:0] IFC_CTRL      = 8'h07;
  localparam logic [7:0] OTG_CTRL      = 8'h0A;
  localparam logic [7:0] USB_INT_EN_R  = 8'h0D;
  localparam logic [7:0] USB_INT_EN_F  = 8'h10;
  localparam logic [7:0] USB_INT_STAT  = 8'h13;
  localparam logic [7:0] USB_INT_LATCH = 8'h14;
  localparam logic [7:0] DEBUG_REG     = 8'h15;
  localparam logic [7:0] SCRATCH       = 8'h16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req [NUM_REQ]  : request bits
//   ptr [IDX_W]    : highest-priority index (must be < NUM_REQ)
//   gnt [NUM_REQ]  : one-hot grant, first set bit at/after ptr, wrapping
//   idx [IDX_W]    : binary index of gnt
//   vld            : any request present
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  int unsigned j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!vld && req[j]) begin
        vld    = 1'b1;
        idx    = IDX_W'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// Round-robin sharing of the bridge's single ULPI register-access port among
// NUM_REQ requesters; one transaction in flight at a time.
//   clk, reset                  : clock, synchronous active-high reset
//   req_i/rd_i/addr_i/wdata_i   : per-requester request (8-bit fields packed n*8)
//   done_o/err_o/rdata_o        : one-cycle completion (+abort) to the grantee
//   reg_req/reg_rd/reg_addr/
//   reg_wdata                   : request to bridge, held until reg_req_done
//   reg_req_done/reg_rdata      : completion pulse and read data from bridge
// Optional: define ULPI_REG_ARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES busy cycles without reg_req_done (done_o+err_o, rdata_o=0).
module ulpi_reg_arbiter
  import ulpi_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   rd_i,
  input  logic [8*NUM_REQ-1:0] addr_i,
  input  logic [8*NUM_REQ-1:0] wdata_i,
  output logic [NUM_REQ-1:0]   done_o,
  output logic [NUM_REQ-1:0]   err_o,
  output logic [7:0]           rdata_o,
  output logic                 reg_req,
  output logic                 reg_rd,
  output logic [7:0]           reg_addr,
  output logic [7:0]           reg_wdata,
  input  logic                 reg_req_done,
  input  logic [7:0]           reg_rdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ulpi_reg_arbiter: NUM_REQ must be 2..8, TIMEOUT_CYCLES >= 1");
  end

  arb_state_e         state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, gnt_idx;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;
  reg_txn_t           sel;
  logic               start, finish, abort, to_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req_i),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  // One-hot AND-OR mux of the winning requester's fields
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (arb_gnt[k]) sel = sel | reg_txn_t'({rd_i[k], addr_i[8*k +: 8], wdata_i[8*k +: 8]});
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      ARB_IDLE: if (arb_vld) begin
        start     = 1'b1;
        state_nxt = ARB_BUSY;
      end
      ARB_BUSY: begin
        // a real completion in the limit cycle beats the timeout
        if (reg_req_done) begin
          finish    = 1'b1;
          state_nxt = ARB_RELEASE;
        end else if (to_hit) begin
          finish    = 1'b1;
          abort     = 1'b1;
          state_nxt = ARB_RELEASE;
        end
      end
      ARB_RELEASE: state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      reg_req   <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      done_o    <= '0;
      rdata_o   <= '0;
    end else begin
      state   <= state_nxt;
      done_o  <= finish ? (NUM_REQ'(1) << gnt_idx) : '0;
      rdata_o <= (finish && !abort && reg_rd) ? reg_rdata : 8'h00;
      if (start) begin
        reg_req   <= 1'b1;
        reg_rd    <= sel.rd;
        reg_addr  <= sel.addr;
        reg_wdata <= sel.wdata;
        gnt_idx   <= arb_idx;
      end
      if (finish) begin
        reg_req <= 1'b0;
        rr_ptr  <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

`ifdef ULPI_REG_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES+1);
  logic [TO_W-1:0] to_cnt;

  // to_cnt equals the index of the current busy cycle (0 on the first)
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      err_o  <= '0;
    end else begin
      err_o <= abort ? (NUM_REQ'(1) << gnt_idx) : '0;
      if (start)                  to_cnt <= '0;
      else if (state == ARB_BUSY) to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err_o  = '0;
`endif

endmodule
